// File: rtl/rx_initiated_point_test_rx_pkg.sv
// Shared codes for the RX-initiated data-to-clock point test.
// The TX-side initiator uses the same sideband message codes and comparator encodings.
package rx_initiated_point_test_rx_pkg;

  localparam logic [3:0] SB_START_REQ        = 4'd1;
  localparam logic [3:0] SB_START_RESP       = 4'd2;
  localparam logic [3:0] SB_LFSR_CLR_REQ     = 4'd3;
  localparam logic [3:0] SB_LFSR_CLR_RESP    = 4'd4;
  localparam logic [3:0] SB_COUNT_DONE_REQ   = 4'd5;
  localparam logic [3:0] SB_COUNT_DONE_RESP  = 4'd6;
  localparam logic [3:0] SB_END_REQ          = 4'd7;
  localparam logic [3:0] SB_END_RESP         = 4'd8;

  localparam logic [1:0] CW_IDLE    = 2'b00;
  localparam logic [1:0] CW_CLEAR   = 2'b01;
  localparam logic [1:0] CW_COMPARE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CLR,
    S_COMPARE,
    S_WAIT_END,
    S_TEST_FINISHED
  } pt_state_e;

endpackage

// File: rtl/rx_initiated_point_test_rx_if.sv
// Sideband link between the SB decoder/wrapper (master) and the point-test responder (slave).
interface rx_initiated_point_test_rx_if #(
  parameter int SB_MSG_WIDTH = 4
);
  logic                    i_rx_msg_valid;
  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg;
  logic                    i_sb_burst_count;
  logic                    i_falling_edge_busy;
  logic                    i_tx_valid;
  logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx;
  logic                    o_valid_rx;

  modport master (
    output i_rx_msg_valid, i_decoded_SB_msg, i_sb_burst_count, i_falling_edge_busy, i_tx_valid,
    input  o_encoded_SB_msg_rx, o_valid_rx
  );

  modport slave (
    input  i_rx_msg_valid, i_decoded_SB_msg, i_sb_burst_count, i_falling_edge_busy, i_tx_valid,
    output o_encoded_SB_msg_rx, o_valid_rx
  );
endinterface

// File: rtl/rx_initiated_point_test_rx_resp_queue.sv
// One-entry response queue feeding the SB wrapper; a response waits while the wrapper is busy
// or owned by the TX sibling, and the newest pushed code wins if two ever collide.
module rx_initiated_point_test_rx_resp_queue #(
  parameter int SB_MSG_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_push,
  input  logic [SB_MSG_WIDTH-1:0] i_push_code,
  input  logic                    i_tx_valid,
  input  logic                    i_falling_edge_busy,
  output logic [SB_MSG_WIDTH-1:0] o_code,
  output logic                    o_valid,
  output logic                    o_pending
);

  logic [SB_MSG_WIDTH-1:0] pend_code;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_code    <= '0;
      o_valid   <= 1'b0;
      o_pending <= 1'b0;
      pend_code <= '0;
    end else if (!i_en) begin
      o_code    <= '0;
      o_valid   <= 1'b0;
      o_pending <= 1'b0;
    end else begin
      if (o_valid && i_falling_edge_busy && !i_tx_valid)
        o_valid <= 1'b0;
      if (i_push) begin
        if (!o_valid && !i_tx_valid) begin
          o_valid   <= 1'b1;
          o_code    <= i_push_code;
          o_pending <= 1'b0;
        end else begin
          o_pending <= 1'b1;
          pend_code <= i_push_code;
        end
      end else if (o_pending && !o_valid && !i_tx_valid) begin
        o_valid   <= 1'b1;
        o_code    <= pend_code;
        o_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_initiated_point_test_rx.sv
// Responder FSM of the RX-initiated data-to-clock point test: answers sideband requests,
// drives the pattern comparator and latches per-lane results.
//   state           | meaning
//   S_IDLE          | waiting for START request
//   S_WAIT_CLR      | START answered, waiting for LFSR clear request
//   S_COMPARE       | comparator clearing (1 cycle) then comparing
//   S_WAIT_END      | results latched, waiting for END request
//   S_TEST_FINISHED | done held until enable drops
module rx_initiated_point_test_rx
  import rx_initiated_point_test_rx_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int NUM_LANES      = 16,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rx_d2c_pt_en,
  rx_initiated_point_test_rx_if.slave sb,
  input  logic [NUM_LANES-1:0]     i_per_lane_error,
  output logic [1:0]               o_comparator_cw,
  output logic                     o_burst_count,
  output logic [NUM_LANES-1:0]     o_lane_results,
  output logic                     o_timeout,
  output logic                     o_rx_d2c_pt_done_rx
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  pt_state_e               state;
  logic [CNT_W-1:0]        wd_cnt;
  logic                    wd_expired;
  logic                    msg_ok;
  logic                    req_start, req_clr, req_cnt_done, req_end;
  logic                    resp_push;
  logic [SB_MSG_WIDTH-1:0] resp_code;
  logic                    resp_pending;

  assign msg_ok       = sb.i_rx_msg_valid && i_rx_d2c_pt_en;
  assign req_start    = msg_ok && (sb.i_decoded_SB_msg == SB_MSG_WIDTH'(SB_START_REQ));
  assign req_clr      = msg_ok && (sb.i_decoded_SB_msg == SB_MSG_WIDTH'(SB_LFSR_CLR_REQ));
  assign req_cnt_done = msg_ok && (sb.i_decoded_SB_msg == SB_MSG_WIDTH'(SB_COUNT_DONE_REQ));
  assign req_end      = msg_ok && (sb.i_decoded_SB_msg == SB_MSG_WIDTH'(SB_END_REQ));
  assign wd_expired   = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Only the request expected in the current state produces a response.
  always_comb begin
    resp_push = 1'b0;
    resp_code = '0;
    case (state)
      S_IDLE:     if (req_start)    begin resp_push = 1'b1; resp_code = SB_MSG_WIDTH'(SB_START_RESP);      end
      S_WAIT_CLR: if (req_clr)      begin resp_push = 1'b1; resp_code = SB_MSG_WIDTH'(SB_LFSR_CLR_RESP);   end
      S_COMPARE:  if (req_cnt_done) begin resp_push = 1'b1; resp_code = SB_MSG_WIDTH'(SB_COUNT_DONE_RESP); end
      S_WAIT_END: if (req_end)      begin resp_push = 1'b1; resp_code = SB_MSG_WIDTH'(SB_END_RESP);        end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= S_IDLE;
      wd_cnt              <= '0;
      o_comparator_cw     <= CW_IDLE;
      o_burst_count       <= 1'b0;
      o_lane_results      <= '0;
      o_timeout           <= 1'b0;
      o_rx_d2c_pt_done_rx <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if (!i_rx_d2c_pt_en) begin
        state               <= S_IDLE;
        wd_cnt              <= '0;
        o_comparator_cw     <= CW_IDLE;
        o_rx_d2c_pt_done_rx <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_start) begin
              state          <= S_WAIT_CLR;
              wd_cnt         <= '0;
              o_burst_count  <= sb.i_sb_burst_count;
              o_lane_results <= '0;
            end
          end
          S_WAIT_CLR: begin
            if (req_clr) begin
              state           <= S_COMPARE;
              wd_cnt          <= '0;
              o_comparator_cw <= CW_CLEAR;
            end else if (wd_expired) begin
              state           <= S_IDLE;
              wd_cnt          <= '0;
              o_timeout       <= 1'b1;
              o_comparator_cw <= CW_IDLE;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          S_COMPARE: begin
            if (o_comparator_cw == CW_CLEAR)
              o_comparator_cw <= CW_COMPARE;
            if (req_cnt_done) begin
              state           <= S_WAIT_END;
              wd_cnt          <= '0;
              o_comparator_cw <= CW_IDLE;
              o_lane_results  <= i_per_lane_error;
            end else if (!resp_pending) begin
              // A clear response stuck behind the TX sibling must not eat into the compare window.
              if (wd_expired) begin
                state           <= S_IDLE;
                wd_cnt          <= '0;
                o_timeout       <= 1'b1;
                o_comparator_cw <= CW_IDLE;
              end else begin
                wd_cnt <= wd_cnt + 1'b1;
              end
            end
          end
          S_WAIT_END: begin
            if (req_end) begin
              state               <= S_TEST_FINISHED;
              wd_cnt              <= '0;
              o_rx_d2c_pt_done_rx <= 1'b1;
            end else if (wd_expired) begin
              state           <= S_IDLE;
              wd_cnt          <= '0;
              o_timeout       <= 1'b1;
              o_comparator_cw <= CW_IDLE;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          S_TEST_FINISHED: o_rx_d2c_pt_done_rx <= 1'b1;
          default: begin
            state  <= S_IDLE;
            wd_cnt <= '0;
          end
        endcase
      end
    end
  end

  rx_initiated_point_test_rx_resp_queue #(
    .SB_MSG_WIDTH(SB_MSG_WIDTH)
  ) u_resp_queue (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_en               (i_rx_d2c_pt_en),
    .i_push             (resp_push),
    .i_push_code        (resp_code),
    .i_tx_valid         (sb.i_tx_valid),
    .i_falling_edge_busy(sb.i_falling_edge_busy),
    .o_code             (sb.o_encoded_SB_msg_rx),
    .o_valid            (sb.o_valid_rx),
    .o_pending          (resp_pending)
  );

endmodule

// File: tb/tb_rx_initiated_point_test_rx.sv
// Directed bench for the point-test responder; expected responses go through a scoreboard queue.
module tb_rx_initiated_point_test_rx;
  import rx_initiated_point_test_rx_pkg::*;

  localparam int W  = 4;
  localparam int NL = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [NL-1:0] lane_err;
  logic [1:0]    cw;
  logic          burst;
  logic [NL-1:0] lane_res;
  logic          tmo;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  rx_initiated_point_test_rx_if #(.SB_MSG_WIDTH(W)) sb();

  rx_initiated_point_test_rx #(
    .SB_MSG_WIDTH  (W),
    .NUM_LANES     (NL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_rx_d2c_pt_en     (en),
    .sb                 (sb),
    .i_per_lane_error   (lane_err),
    .o_comparator_cw    (cw),
    .o_burst_count      (burst),
    .o_lane_results     (lane_res),
    .o_timeout          (tmo),
    .o_rx_d2c_pt_done_rx(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive a request for one cycle starting at a negedge; returns at the negedge after the sampling edge.
  task automatic send_req(input logic [W-1:0] code, input logic bc);
    sb.i_decoded_SB_msg = code;
    sb.i_sb_burst_count = bc;
    sb.i_rx_msg_valid   = 1'b1;
    @(negedge clk);
    sb.i_rx_msg_valid   = 1'b0;
    sb.i_decoded_SB_msg = '0;
  endtask

  task automatic pop_resp(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed_valid=%0b", tag, sb.o_valid_rx);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(sb.o_valid_rx), 32'd1);
      chk({tag, "_code"}, 32'(sb.o_encoded_SB_msg_rx), 32'(e));
    end
  endtask

  task automatic busy_fall();
    sb.i_falling_edge_busy = 1'b1;
    @(negedge clk);
    sb.i_falling_edge_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    lane_err = '0;
    sb.i_rx_msg_valid = 1'b0;
    sb.i_decoded_SB_msg = '0;
    sb.i_sb_burst_count = 1'b0;
    sb.i_falling_edge_busy = 1'b0;
    sb.i_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(sb.o_valid_rx), 0);
    chk("rst_code", 32'(sb.o_encoded_SB_msg_rx), 0);
    chk("rst_cw", 32'(cw), 0);
    chk("rst_burst", 32'(burst), 0);
    chk("rst_lanes", 32'(lane_res), 0);
    chk("rst_timeout", 32'(tmo), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);

    // Full flow with burst=1 and lane errors 0x0081
    exp_q.push_back(SB_START_RESP);
    send_req(SB_START_REQ, 1'b1);
    pop_resp("t1_start");
    chk("t1_burst", 32'(burst), 1);
    chk("t1_cw_idle", 32'(cw), 0);
    busy_fall();
    chk("t1_start_valid_drop", 32'(sb.o_valid_rx), 0);

    exp_q.push_back(SB_LFSR_CLR_RESP);
    send_req(SB_LFSR_CLR_REQ, 1'b0);
    pop_resp("t1_clr");
    chk("t1_cw_clear", 32'(cw), 32'(CW_CLEAR));
    busy_fall();
    chk("t1_cw_compare", 32'(cw), 32'(CW_COMPARE));
    chk("t1_clr_valid_drop", 32'(sb.o_valid_rx), 0);
    repeat (3) @(negedge clk);
    chk("t1_cw_compare_hold", 32'(cw), 32'(CW_COMPARE));

    lane_err = 16'h0081;
    exp_q.push_back(SB_COUNT_DONE_RESP);
    send_req(SB_COUNT_DONE_REQ, 1'b0);
    lane_err = 16'hffff;
    pop_resp("t1_cnt_done");
    chk("t2_lanes", 32'(lane_res), 32'h0081);
    chk("t1_cw_after_done", 32'(cw), 0);
    chk("t1_done_early", 32'(done), 0);
    busy_fall();
    chk("t2_lanes_hold", 32'(lane_res), 32'h0081);

    exp_q.push_back(SB_END_RESP);
    send_req(SB_END_REQ, 1'b0);
    pop_resp("t1_end");
    chk("t1_done", 32'(done), 1);
    busy_fall();
    repeat (2) @(negedge clk);
    chk("t1_done_hold", 32'(done), 1);

    en = 1'b0;
    @(negedge clk);
    chk("t1_done_clear", 32'(done), 0);
    chk("t2_lanes_after_dis", 32'(lane_res), 32'h0081);
    chk("t1_burst_after_dis", 32'(burst), 1);
    en = 1'b1;
    lane_err = '0;
    @(negedge clk);

    // Out-of-order COUNT_DONE in WAIT_CLR, then TX sibling holding the wrapper
    exp_q.push_back(SB_START_RESP);
    send_req(SB_START_REQ, 1'b0);
    pop_resp("t6_start");
    chk("t6_burst", 32'(burst), 0);
    chk("t6_lanes_cleared", 32'(lane_res), 0);
    busy_fall();
    send_req(SB_COUNT_DONE_REQ, 1'b0);
    chk("t6_no_resp", 32'(sb.o_valid_rx), 0);
    chk("t6_cw", 32'(cw), 0);
    @(negedge clk);
    chk("t6_no_resp_later", 32'(sb.o_valid_rx), 0);

    sb.i_tx_valid = 1'b1;
    exp_q.push_back(SB_LFSR_CLR_RESP);
    send_req(SB_LFSR_CLR_REQ, 1'b0);
    chk("t3_held_valid", 32'(sb.o_valid_rx), 0);
    chk("t6_clr_accepted_cw", 32'(cw), 32'(CW_CLEAR));
    repeat (2) @(negedge clk);
    chk("t3_still_held", 32'(sb.o_valid_rx), 0);
    chk("t3_cw_compare", 32'(cw), 32'(CW_COMPARE));
    sb.i_tx_valid = 1'b0;
    @(negedge clk);
    pop_resp("t3_release");

    // Enable drop in COMPARE while a response is still showing
    en = 1'b0;
    @(negedge clk);
    chk("t4_cw", 32'(cw), 0);
    chk("t4_valid", 32'(sb.o_valid_rx), 0);
    chk("t4_done", 32'(done), 0);
    en = 1'b1;
    @(negedge clk);

    // Watchdog in WAIT_CLR
    exp_q.push_back(SB_START_RESP);
    send_req(SB_START_REQ, 1'b1);
    pop_resp("t5_start");
    busy_fall();
    repeat (14) @(negedge clk);
    chk("t5_no_timeout_yet", 32'(tmo), 0);
    @(negedge clk);
    chk("t5_timeout_pulse", 32'(tmo), 1);
    chk("t5_cw", 32'(cw), 0);
    @(negedge clk);
    chk("t5_timeout_single", 32'(tmo), 0);
    exp_q.push_back(SB_START_RESP);
    send_req(SB_START_REQ, 1'b0);
    pop_resp("t5_idle_restart");
    busy_fall();
    exp_q.push_back(SB_LFSR_CLR_RESP);
    send_req(SB_LFSR_CLR_REQ, 1'b0);
    pop_resp("t5_clr");
    chk("t5_cw_clear", 32'(cw), 32'(CW_CLEAR));
    busy_fall();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
